fpr_file_mp: RTL and testbench

Parametrised floating-point register file for the multicycle datapath. It adds three things a plain register file lacks:
- double-precision even/odd pair access;
- write-through read bypass;
- a per-register pending scoreboard for multicycle FP operations.

It sits between decode (two source reads plus destination issue) and FP write-back. Its `hazard` output drives the control FSM's stall.

---
 rtl/fpr_pkg.sv | 32 +++
 rtl/fpr_file_mp_if.sv | 47 ++++
 rtl/fpr_scoreboard.sv | 35 +++
 rtl/fpr_file_mp.sv | 95 +++++++++
 tb/tb_fpr_file_mp.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/fpr_pkg.sv
// Shared constants and mask helper for the multicycle FP register file.
// pair_mask is the single source of truth for which registers an access touches.
package fpr_pkg;

    localparam int FPR_DATA_W   = 32;
    localparam int FPR_NUM_REGS = 32;

    // Widest register file the mask helper can describe; callers slice down to NUM_REGS.
    localparam int FPR_IDX_W    = 10;
    localparam int FPR_MAX_REGS = 1 << FPR_IDX_W;

    // One-hot mask of the register(s) an access covers: one bit for a single
    // access, the even/odd pair (bit 0 of addr ignored) for a double access.
    function automatic logic [FPR_MAX_REGS-1:0] pair_mask(
        input logic [FPR_IDX_W-1:0] addr,
        input logic                 dbl
    );
        logic [FPR_MAX_REGS-1:0] mask;
        logic [FPR_IDX_W-1:0]    base;
        mask = '0;
        if (dbl) begin
            base       = {addr[FPR_IDX_W-1:1], 1'b0};
            mask[base] = 1'b1;
            mask[{addr[FPR_IDX_W-1:1], 1'b1}] = 1'b1;
        end else begin
            base       = addr;
            mask[base] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/fpr_file_mp_if.sv
// Decode / write-back bundle of the FP register file.
// master = decode + write-back side, slave = register file.
interface fpr_file_mp_if
    import fpr_pkg::*;
#(
    parameter int DATA_W   = FPR_DATA_W,
    parameter int NUM_REGS = FPR_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
);

    // Strobe semantics: there is no back-pressure. wr_en and issue_en each
    // qualify their address/data in the cycle they are high and are consumed
    // at that rising edge; hazard is advisory and the file never refuses
    // a strobe, so decode must hold issue_en low while hazard is high.
    logic [ADDR_W-1:0]   rs_a;
    logic [ADDR_W-1:0]   rs_b;
    logic                rd_dbl;
    logic [2*DATA_W-1:0] bus_a;
    logic [2*DATA_W-1:0] bus_b;

    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic                wr_dbl;
    logic [2*DATA_W-1:0] bus_w;

    logic                issue_en;
    logic [ADDR_W-1:0]   issue_addr;
    logic                issue_dbl;

    logic [NUM_REGS-1:0] pending;
    logic                hazard;

    modport master (
        output rs_a, rs_b, rd_dbl,
        output wr_en, wr_addr, wr_dbl, bus_w,
        output issue_en, issue_addr, issue_dbl,
        input  bus_a, bus_b, pending, hazard
    );

    modport slave (
        input  rs_a, rs_b, rd_dbl,
        input  wr_en, wr_addr, wr_dbl, bus_w,
        input  issue_en, issue_addr, issue_dbl,
        output bus_a, bus_b, pending, hazard
    );

endinterface

// File: rtl/fpr_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
// hazard flags any checked register still pending and not being written this cycle.
module fpr_scoreboard
    import fpr_pkg::*;
#(
    parameter int NUM_REGS = FPR_NUM_REGS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] set_mask,
    input  logic [NUM_REGS-1:0] clr_mask,
    input  logic [NUM_REGS-1:0] chk_a,
    input  logic [NUM_REGS-1:0] chk_b,
    input  logic [NUM_REGS-1:0] chk_i,
    output logic [NUM_REGS-1:0] pending,
    output logic                hazard
);

    logic [NUM_REGS-1:0] chk_all;

    // Set is applied after clear so a same-cycle re-issue keeps the bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | set_mask;
        end
    end

    always_comb begin
        chk_all = chk_a | chk_b | chk_i;
        hazard  = |(chk_all & pending & ~clr_mask);
    end

endmodule

// File: rtl/fpr_file_mp.sv
// FP register file with even/odd pair access, write-through read bypass and
// a pending scoreboard that raises hazard for the decode stall logic.
module fpr_file_mp
    import fpr_pkg::*;
#(
    parameter int DATA_W   = FPR_DATA_W,
    parameter int NUM_REGS = FPR_NUM_REGS,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic          clk,
    input  logic          reset,
    fpr_file_mp_if.slave  fp
);

    logic [DATA_W-1:0]   regs    [NUM_REGS];
    logic [DATA_W-1:0]   wr_word [NUM_REGS];
    logic [DATA_W-1:0]   view    [NUM_REGS];
    logic [NUM_REGS-1:0] wr_mask;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] chk_a;
    logic [NUM_REGS-1:0] chk_b;
    logic [NUM_REGS-1:0] chk_i;
    logic [ADDR_W-1:0]   even_a;
    logic [ADDR_W-1:0]   odd_a;
    logic [ADDR_W-1:0]   even_b;
    logic [ADDR_W-1:0]   odd_b;

    function automatic logic [NUM_REGS-1:0] reg_mask(
        input logic [ADDR_W-1:0] addr,
        input logic              dbl
    );
        logic [FPR_MAX_REGS-1:0] full;
        full = pair_mask(FPR_IDX_W'(addr), dbl);
        return full[NUM_REGS-1:0];
    endfunction

    always_comb begin
        wr_mask  = fp.wr_en    ? reg_mask(fp.wr_addr, fp.wr_dbl)       : '0;
        set_mask = fp.issue_en ? reg_mask(fp.issue_addr, fp.issue_dbl) : '0;
        chk_a    = reg_mask(fp.rs_a, fp.rd_dbl);
        chk_b    = reg_mask(fp.rs_b, fp.rd_dbl);
        chk_i    = set_mask;
    end

    // Even registers of a pair take the upper half of bus_w; everything else the lower half.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_word
        assign wr_word[g] = (fp.wr_dbl && (g % 2 == 0)) ? fp.bus_w[2*DATA_W-1:DATA_W]
                                                          : fp.bus_w[DATA_W-1:0];
        assign view[g]    = wr_mask[g] ? wr_word[g] : regs[g];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_mask[i]) begin
                    regs[i] <= wr_word[i];
                end
            end
        end
    end

    // Read ports see the bypassed view, so forwarding is naturally per word.
    always_comb begin
        even_a = {fp.rs_a[ADDR_W-1:1], 1'b0};
        odd_a  = {fp.rs_a[ADDR_W-1:1], 1'b1};
        even_b = {fp.rs_b[ADDR_W-1:1], 1'b0};
        odd_b  = {fp.rs_b[ADDR_W-1:1], 1'b1};
        if (fp.rd_dbl) begin
            fp.bus_a = {view[even_a], view[odd_a]};
            fp.bus_b = {view[even_b], view[odd_b]};
        end else begin
            fp.bus_a = {{DATA_W{1'b0}}, view[fp.rs_a]};
            fp.bus_b = {{DATA_W{1'b0}}, view[fp.rs_b]};
        end
    end

    fpr_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_mask (set_mask),
        .clr_mask (wr_mask),
        .chk_a    (chk_a),
        .chk_b    (chk_b),
        .chk_i    (chk_i),
        .pending  (fp.pending),
        .hazard   (fp.hazard)
    );

endmodule

// File: tb/tb_fpr_file_mp.sv
// Directed bench for fpr_file_mp: a per-cycle vector table plus a reset-mid-operation sequence.
module tb_fpr_file_mp;

    localparam int DW = 32;
    localparam int NR = 32;
    localparam int AW = 5;

    typedef struct packed {
        logic [AW-1:0]   rs_a;
        logic [AW-1:0]   rs_b;
        logic            rd_dbl;
        logic            wr_en;
        logic [AW-1:0]   wr_addr;
        logic            wr_dbl;
        logic [2*DW-1:0] bus_w;
        logic            iss_en;
        logic [AW-1:0]   iss_addr;
        logic            iss_dbl;
        logic [2*DW-1:0] exp_a;
        logic [2*DW-1:0] exp_b;
        logic            exp_haz;
        logic [NR-1:0]   exp_pend;
    } vec_t;

    localparam int NV = 17;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    vec_t vecs [NV];
    logic [2*DW-1:0] exp_q [$];

    fpr_file_mp_if #(.DATA_W(DW), .NUM_REGS(NR)) fp ();

    fpr_file_mp #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .fp    (fp)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive_idle();
        fp.rs_a = '0; fp.rs_b = '0; fp.rd_dbl = 1'b0;
        fp.wr_en = 1'b0; fp.wr_addr = '0; fp.wr_dbl = 1'b0; fp.bus_w = '0;
        fp.issue_en = 1'b0; fp.issue_addr = '0; fp.issue_dbl = 1'b0;
    endtask

    task automatic drive_vec(input vec_t v);
        fp.rs_a = v.rs_a; fp.rs_b = v.rs_b; fp.rd_dbl = v.rd_dbl;
        fp.wr_en = v.wr_en; fp.wr_addr = v.wr_addr; fp.wr_dbl = v.wr_dbl; fp.bus_w = v.bus_w;
        fp.issue_en = v.iss_en; fp.issue_addr = v.iss_addr; fp.issue_dbl = v.iss_dbl;
    endtask

    // Scoreboard checks
    task automatic check_bus(input string name, input logic [2*DW-1:0] act);
        logic [2*DW-1:0] exp;
        exp = exp_q.pop_front();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_pend(input string name, input logic [NR-1:0] act, input logic [NR-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        //            rs_a   rs_b   dbl   wr    waddr  wdbl  bus_w                  iss   iaddr  idbl  exp_a                  exp_b                  haz   pend
        vecs[0]  = '{5'd7,  5'd0,  1'b0, 1'b1, 5'd7,  1'b0, 64'h00000000_40490FDB, 1'b0, 5'd0,  1'b0, 64'h00000000_40490FDB, 64'h0,                 1'b0, 32'h0};
        vecs[1]  = '{5'd7,  5'd7,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b0, 5'd0,  1'b0, 64'h00000000_40490FDB, 64'h00000000_40490FDB, 1'b0, 32'h0};
        vecs[2]  = '{5'd2,  5'd3,  1'b1, 1'b1, 5'd3,  1'b1, 64'h400921FB_54442D18, 1'b0, 5'd0,  1'b0, 64'h400921FB_54442D18, 64'h400921FB_54442D18, 1'b0, 32'h0};
        vecs[3]  = '{5'd2,  5'd3,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b0, 5'd0,  1'b0, 64'h00000000_400921FB, 64'h00000000_54442D18, 1'b0, 32'h0};
        vecs[4]  = '{5'd3,  5'd6,  1'b1, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b0, 5'd0,  1'b0, 64'h400921FB_54442D18, 64'h00000000_40490FDB, 1'b0, 32'h0};
        vecs[5]  = '{5'd7,  5'd6,  1'b1, 1'b1, 5'd6,  1'b0, 64'hDEADBEEF_11112222, 1'b0, 5'd0,  1'b0, 64'h11112222_40490FDB, 64'h11112222_40490FDB, 1'b0, 32'h0};
        vecs[6]  = '{5'd0,  5'd1,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b1, 5'd8,  1'b1, 64'h0,                 64'h0,                 1'b0, 32'h0};
        vecs[7]  = '{5'd0,  5'd9,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b0, 5'd0,  1'b0, 64'h0,                 64'h0,                 1'b1, 32'h300};
        vecs[8]  = '{5'd8,  5'd9,  1'b0, 1'b1, 5'd8,  1'b1, 64'hAAAA0001_BBBB0002, 1'b0, 5'd0,  1'b0, 64'h00000000_AAAA0001, 64'h00000000_BBBB0002, 1'b0, 32'h300};
        vecs[9]  = '{5'd8,  5'd9,  1'b1, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b1, 5'd10, 1'b0, 64'hAAAA0001_BBBB0002, 64'hAAAA0001_BBBB0002, 1'b0, 32'h0};
        vecs[10] = '{5'd10, 5'd0,  1'b0, 1'b1, 5'd10, 1'b0, 64'h00000000_12345678, 1'b1, 5'd10, 1'b0, 64'h00000000_12345678, 64'h0,                 1'b0, 32'h400};
        vecs[11] = '{5'd10, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b1, 5'd12, 1'b0, 64'h00000000_12345678, 64'h0,                 1'b1, 32'h400};
        vecs[12] = '{5'd0,  5'd1,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b1, 5'd12, 1'b0, 64'h0,                 64'h0,                 1'b1, 32'h1400};
        vecs[13] = '{5'd12, 5'd0,  1'b0, 1'b1, 5'd12, 1'b0, 64'h55550000_00000099, 1'b0, 5'd0,  1'b0, 64'h00000000_00000099, 64'h0,                 1'b0, 32'h1400};
        vecs[14] = '{5'd11, 5'd12, 1'b1, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b0, 5'd0,  1'b0, 64'h12345678_00000000, 64'h00000099_00000000, 1'b1, 32'h400};
        vecs[15] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b1, 5'd5,  1'b1, 64'h0,                 64'h0,                 1'b0, 32'h400};
        vecs[16] = '{5'd4,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 64'h0,                 1'b0, 5'd0,  1'b0, 64'h0,                 64'h0,                 1'b1, 32'h430};

        // Reset and its visible state
        reset = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        fp.rs_a = 5'd5;
        fp.rs_b = 5'd31;
        #1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        check_bus("reset_bus_a", fp.bus_a);
        check_bus("reset_bus_b", fp.bus_b);
        check_bit("reset_hazard", fp.hazard, 1'b0);
        check_pend("reset_pending", fp.pending, '0);

        // Table: one row per cycle, outputs checked before the committing edge
        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive_vec(vecs[i]);
            exp_q.push_back(vecs[i].exp_a);
            exp_q.push_back(vecs[i].exp_b);
            #1;
            check_bus($sformatf("row%0d_bus_a", i), fp.bus_a);
            check_bus($sformatf("row%0d_bus_b", i), fp.bus_b);
            check_bit($sformatf("row%0d_hazard", i), fp.hazard, vecs[i].exp_haz);
            check_pend($sformatf("row%0d_pending", i), fp.pending, vecs[i].exp_pend);
        end

        // Write f4 while it is pending: bypassed, and no hazard on it
        @(posedge clk);
        #1;
        drive_idle();
        fp.wr_en = 1'b1; fp.wr_addr = 5'd4; fp.bus_w = 64'h00000000_3F800000;
        fp.rs_a  = 5'd4;
        #1;
        exp_q.push_back(64'h00000000_3F800000);
        check_bus("f4_bypass", fp.bus_a);
        check_bit("f4_write_no_hazard", fp.hazard, 1'b0);

        @(posedge clk);
        #1;
        drive_idle();
        fp.rs_a = 5'd4;
        #1;
        exp_q.push_back(64'h00000000_3F800000);
        check_bus("f4_stored", fp.bus_a);
        check_pend("f4_pending_cleared", fp.pending, 32'h420);

        // Reset lands together with a write to f5; the write must be dropped
        @(posedge clk);
        #1;
        reset = 1'b1;
        fp.wr_en = 1'b1; fp.wr_addr = 5'd5; fp.bus_w = 64'h00000000_CAFEF00D;
        fp.issue_en = 1'b1; fp.issue_addr = 5'd14;

        @(posedge clk);
        #1;
        reset = 1'b0;
        drive_idle();
        fp.rs_a = 5'd4;
        fp.rs_b = 5'd5;
        #1;
        exp_q.push_back(64'h0);
        exp_q.push_back(64'h0);
        check_bus("midreset_f4", fp.bus_a);
        check_bus("midreset_f5", fp.bus_b);
        check_pend("midreset_pending", fp.pending, '0);
        check_bit("midreset_hazard", fp.hazard, 1'b0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
